// File: rtl/opcode_pkg.sv
// Shared definitions for the opcode scheduler: opcodes, FSM state encoding
// and default widths. The optional iterative divider is enabled by defining
// OPCODE_SCHED_DIV_EN.
package opcode_pkg;

    localparam int DEF_A_W = 12;
    localparam int DEF_D_W = 32;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_DIV  = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/opcode_divider.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock.
// start loads the operands; busy covers the A_W iterations; done is high in
// the cycle whose closing edge performs the last step, so the caller can
// leave its wait state on that same edge. Results hold until the next start.
// Only instantiated when OPCODE_SCHED_DIV_EN is defined.
module opcode_divider
    import opcode_pkg::*;
#(
    parameter int A_W = DEF_A_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [A_W-1:0] dividend,
    input  logic [A_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [A_W-1:0] quotient,
    output logic [A_W-1:0] remainder
);

    localparam int CW = $clog2(A_W + 1);

    logic [CW-1:0]  cnt;
    logic [A_W-1:0] dvs;
    logic [A_W:0]   trial;
    logic           fits;
    logic [A_W-1:0] rem_next;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if it does not underflow.
    always_comb begin
        trial    = {remainder, quotient[A_W-1]};
        fits     = (trial >= {1'b0, dvs});
        rem_next = fits ? A_W'(trial - {1'b0, dvs}) : trial[A_W-1:0];
    end

    assign done = busy && (cnt == CW'(1));

    // Iteration counter and busy flag; reset aborts a division in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(A_W);
        end else if (busy) begin
            busy <= (cnt != CW'(1));
            cnt  <= cnt - CW'(1);
        end
    end

    // Datapath: quotient shifts in from the bottom as the dividend shifts out the top.
    always_ff @(posedge clk) begin
        if (start) begin
            quotient  <= dividend;
            remainder <= '0;
            dvs       <= divisor;
        end else if (busy) begin
            quotient  <= {quotient[A_W-2:0], fits};
            remainder <= rem_next;
        end
    end

endmodule

// File: rtl/opcode_sched.sv
// Two-port round-robin scheduler in front of a shared opcode ALU.
// Add/sub/mul/other ops complete at the accept edge; div/mod run on the
// iterative divider when OPCODE_SCHED_DIV_EN is defined, otherwise they are
// reported as unsupported (rsp_d = opcode, rsp_err = 1) with 1-cycle latency.
// The result is held on a valid/ready response port until consumed.
module opcode_sched
    import opcode_pkg::*;
#(
    parameter int A_W = DEF_A_W,
    parameter int D_W = DEF_D_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [7:0]       req_op,
    input  logic [2*A_W-1:0] req_a,
    input  logic [2*A_W-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [D_W-1:0]   rsp_d,
    output logic             rsp_err,
    output logic             busy
);

    state_t         state;
    logic           last;
    logic           grant;
    logic           accept;
    logic [3:0]     sel_op;
    logic [A_W-1:0] sel_a;
    logic [A_W-1:0] sel_b;
    logic           rsp_id_r;
    logic           rsp_err_r;
    logic [D_W-1:0] rsp_d_r;

    // Single-cycle ALU; returns {err, result}. Div/mod land here only when
    // the divider is not built, and are then flagged as unsupported.
    function automatic logic [D_W:0] alu(input logic [3:0] op,
                                         input logic [A_W-1:0] a,
                                         input logic [A_W-1:0] b);
        logic [D_W-1:0] ax;
        logic [D_W-1:0] bx;
        ax = D_W'(a);
        bx = D_W'(b);
        if (is_div_op(op))
            return {1'b1, D_W'(op)};
        case (op)
            OP_ADD:  return {1'b0, ax + bx};
            OP_SUB:  return {1'b0, ax - bx};
            OP_MUL:  return {1'b0, ax * bx};
            default: return {1'b0, D_W'(op)};
        endcase
    endfunction

    // Round-robin grant and request mux; ready depends only on req_valid and registered state.
    always_comb begin
        grant     = (req_valid == 2'b11) ? ~last : req_valid[1];
        sel_op    = grant ? req_op[7:4] : req_op[3:0];
        sel_a     = grant ? req_a[2*A_W-1:A_W] : req_a[A_W-1:0];
        sel_b     = grant ? req_b[2*A_W-1:A_W] : req_b[A_W-1:0];
        req_ready = 2'b00;
        if (state == ST_IDLE)
            req_ready = req_valid & (grant ? 2'b10 : 2'b01);
        accept    = |(req_valid & req_ready);
    end

`ifdef OPCODE_SCHED_DIV_EN
    logic           sel_div;
    logic           is_mod;
    logic           div_zero;
    logic           b_zero;
    logic           dv_start;
    logic           dv_busy;
    logic           dv_done;
    logic [A_W-1:0] dv_quo;
    logic [A_W-1:0] dv_rem;

    assign b_zero   = (sel_b == '0);
    assign dv_start = accept && is_div_op(sel_op) && !b_zero;

    opcode_divider #(.A_W(A_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (dv_start),
        .dividend  (sel_a),
        .divisor   (sel_b),
        .busy      (dv_busy),
        .done      (dv_done),
        .quotient  (dv_quo),
        .remainder (dv_rem)
    );

    // Divider results are read straight from its held registers once it finishes.
    assign rsp_d = sel_div ? (is_mod ? D_W'(dv_rem) : D_W'(dv_quo)) : rsp_d_r;
    assign busy  = (state != ST_IDLE) | dv_busy;
`else
    assign rsp_d = rsp_d_r;
    assign busy  = (state != ST_IDLE);
`endif

    assign rsp_valid = (state == ST_RESP);
    assign rsp_id    = rsp_id_r;
    assign rsp_err   = rsp_err_r;

    // Scheduler FSM: accept in IDLE, wait on the divider in DIV, hold the result in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            last      <= 1'b1;
            rsp_id_r  <= 1'b0;
            rsp_err_r <= 1'b0;
            rsp_d_r   <= '0;
`ifdef OPCODE_SCHED_DIV_EN
            sel_div   <= 1'b0;
            is_mod    <= 1'b0;
            div_zero  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        last     <= grant;
                        rsp_id_r <= grant;
`ifdef OPCODE_SCHED_DIV_EN
                        if (is_div_op(sel_op)) begin
                            // Divide-by-zero result is known now; DIV then lasts one cycle.
                            state     <= ST_DIV;
                            is_mod    <= (sel_op == OP_MOD);
                            div_zero  <= b_zero;
                            sel_div   <= !b_zero;
                            rsp_err_r <= b_zero;
                            rsp_d_r   <= (sel_op == OP_MOD) ? D_W'(sel_a) : '1;
                        end else begin
                            state                  <= ST_RESP;
                            sel_div                <= 1'b0;
                            {rsp_err_r, rsp_d_r}   <= alu(sel_op, sel_a, sel_b);
                        end
`else
                        state                <= ST_RESP;
                        {rsp_err_r, rsp_d_r} <= alu(sel_op, sel_a, sel_b);
`endif
                    end
                end
                ST_DIV: begin
`ifdef OPCODE_SCHED_DIV_EN
                    if (div_zero || dv_done)
                        state <= ST_RESP;
`else
                    state <= ST_IDLE;
`endif
                end
                ST_RESP: begin
                    if (rsp_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_opcode_sched.sv
// Scoreboard bench for opcode_sched. Drivers issue requests on both ports;
// a monitor predicts grants with its own round-robin model, pushes the
// expected result (computed with plain arithmetic) on each accept, and pops
// and compares whenever a response is due. Covers both build variants.
module tb_opcode_sched;

    typedef struct {
        logic [3:0]  op;
        logic [11:0] a;
        logic [11:0] b;
    } req_t;

    typedef struct {
        logic        id;
        logic [31:0] d;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [7:0]  req_op = '0;
    logic [23:0] req_a = '0;
    logic [23:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_d;
    logic        rsp_err;
    logic        busy;

    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   mode   = 0;
    int   hold_cnt = 0;
    bit   gaps   = 1'b0;
    req_t q0[$];
    req_t q1[$];
    exp_t sb[$];

    logic       last_m = 1'b1;
    logic       eg;
    logic [1:0] er;
    logic       due;
    int         gi;
    exp_t       e;

    opcode_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_d     (rsp_d),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference results from the arithmetic rules, returned as {err, d}.
    function automatic logic [32:0] model(input logic [3:0] op, input logic [11:0] a, input logic [11:0] b);
        int unsigned ua;
        int unsigned ub;
        ua = 32'(a);
        ub = 32'(b);
        case (op)
            4'd0: return {1'b0, 32'(ua + ub)};
            4'd1: return {1'b0, 32'(ua - ub)};
            4'd2: return {1'b0, 32'(ua * ub)};
            4'd3, 4'd4: begin
`ifdef OPCODE_SCHED_DIV_EN
                if (ub == 0) return (op == 4'd3) ? {1'b1, 32'hFFFF_FFFF} : {1'b1, ua};
                return (op == 4'd3) ? {1'b0, ua / ub} : {1'b0, ua % ub};
`else
                return {1'b1, 32'(op)};
`endif
            end
            default: return {1'b0, 32'(op)};
        endcase
    endfunction

    function automatic int latency(input logic [3:0] op, input logic [11:0] b);
`ifdef OPCODE_SCHED_DIV_EN
        if (op == 4'd3 || op == 4'd4) return (b == 12'd0) ? 2 : 13;
`endif
        return 1;
    endfunction

    // Consumer side: always ready, random, 5-cycle hold, or never ready.
    always @(posedge clk) begin
        #1;
        if (rsp_valid) hold_cnt++;
        else hold_cnt = 0;
        case (mode)
            1:       rsp_ready = 1'($urandom_range(0, 1));
            2:       rsp_ready = (hold_cnt > 5);
            3:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
        endcase
    end

    // Monitor/scoreboard: checks grants, busy, response timing and contents.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            last_m = 1'b1;
        end else begin
            eg = (req_valid == 2'b11) ? ~last_m : req_valid[1];
            er = (sb.size() > 0) ? 2'b00 : (req_valid & (eg ? 2'b10 : 2'b01));
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("busy", 32'(busy), 32'(sb.size() > 0));
            due = (sb.size() > 0) && (cyc >= sb[0].acc + sb[0].lat);
            chk("rsp_valid", 32'(rsp_valid), 32'(due));
            if (due && rsp_valid) begin
                chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                chk("rsp_d", rsp_d, sb[0].d);
                chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
                if (rsp_ready) void'(sb.pop_front());
            end
            if (er != 2'b00) begin
                gi = int'(eg);
                e.id  = eg;
                {e.err, e.d} = model(req_op[4*gi +: 4], req_a[12*gi +: 12], req_b[12*gi +: 12]);
                e.acc = cyc;
                e.lat = latency(req_op[4*gi +: 4], req_b[12*gi +: 12]);
                sb.push_back(e);
                last_m = eg;
            end
        end
    end

    task automatic load(input int i, output bit active);
        req_t r;
        active = 1'b0;
        req_valid[i] = 1'b0;
        if (i == 0 && q0.size() > 0) begin r = q0.pop_front(); active = 1'b1; end
        if (i == 1 && q1.size() > 0) begin r = q1.pop_front(); active = 1'b1; end
        if (active) begin
            req_valid[i]      = 1'b1;
            req_op[4*i +: 4]  = r.op;
            req_a[12*i +: 12] = r.a;
            req_b[12*i +: 12] = r.b;
        end
    endtask

    // Drive both queues until every request has been accepted.
    task automatic run_drivers();
        bit act[2];
        bit acc[2];
        bit pend[2];
        int n;
        n = 0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) load(i, act[i]);
        while (act[0] || act[1]) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) acc[i] = act[i] && req_valid[i] && req_ready[i];
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    if (gaps && $urandom_range(0, 3) == 0) begin
                        req_valid[i] = 1'b0;
                        pend[i] = 1'b1;
                    end else load(i, act[i]);
                end else if (pend[i]) begin
                    pend[i] = 1'b0;
                    load(i, act[i]);
                end
            end
            n++;
            if (n > 5000) begin
                total++;
                $display("FAIL accept_timeout: requests still pending after %0d cycles", n);
                q0.delete();
                q1.delete();
                req_valid = 2'b00;
                break;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        chk({tag, "_rsp_d"},     rsp_d,          32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    function automatic req_t mk(input logic [3:0] op, input logic [11:0] a, input logic [11:0] b);
        req_t r;
        r.op = op;
        r.a  = a;
        r.b  = b;
        return r;
    endfunction

    function automatic req_t rand_req();
        int k;
        req_t r;
        k = $urandom_range(0, 7);
        r.op = (k < 5) ? 4'(k) : 4'($urandom_range(5, 15));
        r.a  = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
        r.b  = ($urandom_range(0, 5) == 0) ? 12'h000 : 12'($urandom);
        return r;
    endfunction

    initial begin
        #1 rst = 1'b1;
        #1 check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single port add at the operand limit.
        mode = 0;
        q0.push_back(mk(4'd0, 12'd4095, 12'd4095));
        run_drivers();
        drain();

        // Both ports valid back-to-back: grants must alternate.
        q0.push_back(mk(4'd2, 12'd100, 12'd200));
        q0.push_back(mk(4'd2, 12'd100, 12'd200));
        q1.push_back(mk(4'd1, 12'd1, 12'd2));
        q1.push_back(mk(4'd1, 12'd1, 12'd2));
        run_drivers();
        drain();

        // Division, modulo, divide-by-zero and an unassigned opcode.
        q1.push_back(mk(4'd3, 12'd1000, 12'd7));
        q1.push_back(mk(4'd4, 12'd1000, 12'd7));
        q0.push_back(mk(4'd3, 12'd5, 12'd0));
        q0.push_back(mk(4'd4, 12'd5, 12'd0));
        q0.push_back(mk(4'd10, 12'd3, 12'd4));
        run_drivers();
        drain();

        // Consumer stalls five cycles while a second port waits.
        mode = 2;
        q0.push_back(mk(4'd0, 12'd7, 12'd9));
        q1.push_back(mk(4'd1, 12'd9, 12'd7));
        run_drivers();
        drain();

        // Reset in the middle of an operation abandons it.
        mode = 3;
        q0.push_back(mk(4'd3, 12'd1000, 12'd7));
        run_drivers();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero_outputs("midop_reset");
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        mode = 0;
        q0.push_back(mk(4'd0, 12'd1, 12'd2));
        q1.push_back(mk(4'd0, 12'd3, 12'd4));
        run_drivers();
        drain();

        // Randomized traffic with random consumer stalls and request gaps.
        mode = 1;
        gaps = 1'b1;
        for (int k = 0; k < 40; k++) begin
            q0.push_back(rand_req());
            q1.push_back(rand_req());
        end
        run_drivers();
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
